window_feeder: RTL and testbench
================================

# window_feeder

Streaming front end for `neuron_unit`. Accepts a raster-ordered 8-bit luminance pixel stream, converts each pixel exactly to IEEE-754 single precision, and buffers six previous image lines. It presents every complete 7x7 window as seven 224-bit row vectors plus a one-cycle `de_out` strobe, wired directly to `neuron_unit`'s `de_in`/`line_*_in`.

## Interface
- IMG_W, 28, pixels per line; legal range 7..1024.
- IMG_H, 28, lines per frame; legal range 7..1024.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- pix_in  in  8  unsigned luminance sample.
- pix_valid  in  1  pixel qualifier; pixel sampled on rising edge while high.
- sof_in  in  1  start of frame; sampled only with pix_valid. Marks the pixel as row 0, col 0.
- de_out  out  1  window-valid strobe, one cycle per emitted window.
- line_0_out..line_6_out  out  224 each  window rows. line_0 is the top (oldest) row, line_6 the bottom (current) row. Within a row, [223:192] is the leftmost (oldest) column and [31:0] the rightmost (current pixel column).

## Operation
- **Conversion (combinational on pix_in):**
  - 0 -> 0x00000000.
  - Otherwise p = index of the MSB of pix_in; exponent = 127+p; mantissa = pix_in bits below the MSB, left-aligned into 23 bits.
  - The result is exact; no rounding.
- **Stage 1 (edge E0, pix_valid high):** register the converted word, the col/row position and a valid bit.
- **Stage 2 (edge E1):** if stage 1 is valid:
  - Read the six line-buffer words at column col. These are the rows row-6..row-1, as 32-bit floats.
  - Shift each of the 7 row shift registers left by one word, inserting the buffer word (rows 0..5) or the new word (row 6) at [31:0].
  - Write the line buffers at col as a rolling 6-deep shift: row-5 moves to row-6, …, new word moves to row-1.
  - Implementation: 6 × IMG_W × 32 storage, RAM or registers.
- **Counters:**
  - col increments per accepted pixel; at IMG_W-1 it wraps to 0 and row increments.
  - At row IMG_H-1, col IMG_W-1, both wrap to 0.
  - sof_in with pix_valid forces that pixel to (0,0) regardless of the current count. Subsequent pixels count from there.
- **de_out:** high for the stage-2 cycle of any pixel with row ≥ 6 and col ≥ 6; low otherwise.
  - This gives (IMG_W-6) × (IMG_H-6) windows per frame, e.g. 484 for 28×28.
- **Window contents:** the emitted window is exactly pixels rows row-6..row, cols col-6..col. No data from the previous line wraps into a window, guaranteed by the col ≥ 6 gate.
- **Stalls:** pix_valid low freezes counters, shift registers, line buffers and line_*_out. de_out is low in the following stage-2 cycle. Gaps of any length are allowed and do not corrupt windows.
- **Reset** (asserted any time, including mid-frame):
  - de_out = 0, all line_*_out = 0, col = row = 0, stage-1 valid = 0.
  - Line-buffer contents are not cleared. Windows are gated until six fresh rows exist.

## Timing
- Throughput is one pixel per clock with no backpressure.
- Latency: pixel sampled at edge E0; its window and de_out are visible after edge E1 and held until E2.
- line_*_out are registered; they change only on cycles following a valid stage 2.
- Reset deassertion is synchronous to clk internally. The first pixel may be sampled on the second rising edge after release.
- sof_in in the same cycle as a row/col wrap: sof_in wins.
- pix_valid with sof_in mid-frame abandons the partial frame. No window is emitted until row 6, col 6 of the new frame.

## Test plan
- **Conversion:** with a 7×7 image (IMG_W = IMG_H = 7), use all pixels 0 except the last, set in turn to 1, 128 and 255. Check line_6_out[31:0] = 0x3F800000, 0x43000000 and 0x437F0000 respectively, and all other words 0x00000000.
- **Full frame:** 28×28 ramp with pix = (row + col) & 0xFF, continuous pix_valid, sof_in on the first pixel.
  - Exactly 484 de_out pulses.
  - The first pulse occurs the cycle after pixel (6,6) is sampled, with line_0_out = floats {0,1,2,3,4,5,6}.
  - Every window matches the reference model.
- **Stalls:** the same frame with random pix_valid gaps of 0–5 cycles. Check identical window sequence and count, de_out never high during gaps, and outputs held.
- **Reset mid-frame:** assert reset at pixel (10,12) → de_out = 0 and outputs = 0 immediately. Then release and send a full frame → exactly 484 windows, with no stale data.
- **SOF resync:** send 300 pixels, then sof_in and a full frame → the first window follows new-frame pixel (6,6), 484 windows total.
- **Back-to-back frames:** two frames without a gap, sof_in only on the first → 968 windows. The second frame starts at (0,0) via wrap.

Source files
------------

// File: rtl/window_feeder.sv
// rtl/window_feeder.sv - 7x7 float window generator for a raster pixel stream
module window_feeder #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  input  logic         sof_in,
  output logic         de_out,
  output logic [223:0] line_0_out,
  output logic [223:0] line_1_out,
  output logic [223:0] line_2_out,
  output logic [223:0] line_3_out,
  output logic [223:0] line_4_out,
  output logic [223:0] line_5_out,
  output logic [223:0] line_6_out
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic          rst_n;
  logic [2:0]    msb;
  logic [6:0]    mant;
  logic [31:0]   pix_word;
  logic [CW-1:0] col_cnt, pix_col, col_next, s1_col;
  logic [RW-1:0] row_cnt, pix_row, row_next, s1_row;
  logic          s1_valid;
  logic [31:0]   s1_word;
  logic [31:0]   lbuf [0:5][0:IMG_W-1];
  logic [31:0]   buf_rd [0:5];
  logic [223:0]  win [0:6];

  // Reset asserts immediately but releases on a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_n <= 1'b0;
    else        rst_n <= 1'b1;
  end

  // Exact u8 -> binary32: exponent from the leading one, remaining bits left-aligned
  always_comb begin
    msb = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pix_in[i]) msb = 3'(i);
    end
    mant = 7'(pix_in << (3'd7 - msb));
    if (pix_in == 8'd0) pix_word = 32'h0000_0000;
    else                pix_word = {1'b0, 8'd127 + {5'd0, msb}, mant, 16'h0000};
  end

  // Position of the incoming pixel (sof forces origin) and the position after it
  always_comb begin
    pix_col  = sof_in ? '0 : col_cnt;
    pix_row  = sof_in ? '0 : row_cnt;
    col_next = pix_col + CW'(1);
    row_next = pix_row;
    if (pix_col == CW'(IMG_W - 1)) begin
      col_next = '0;
      if (pix_row == RW'(IMG_H - 1)) row_next = '0;
      else                           row_next = pix_row + RW'(1);
    end
  end

  // Stage 1: capture converted pixel with its position; advance raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_word <= pix_word;
        s1_col  <= pix_col;
        s1_row  <= pix_row;
        col_cnt <= col_next;
        row_cnt <= row_next;
      end
    end
  end

  // Column slice of the six stored lines: index 0 is row-6, index 5 is row-1
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      buf_rd[k] = lbuf[k][s1_col];
    end
  end

  // Line buffers roll one row older at this column; contents survive reset
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      for (int k = 0; k < 5; k++) begin
        lbuf[k][s1_col] <= lbuf[k+1][s1_col];
      end
      lbuf[5][s1_col] <= s1_word;
    end
  end

  // Stage 2: shift the column into the window and flag windows fully inside this frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out <= 1'b0;
      for (int k = 0; k < 7; k++) begin
        win[k] <= '0;
      end
    end else begin
      de_out <= s1_valid && (s1_row >= RW'(6)) && (s1_col >= CW'(6));
      if (s1_valid) begin
        for (int k = 0; k < 6; k++) begin
          win[k] <= {win[k][191:0], buf_rd[k]};
        end
        win[6] <= {win[6][191:0], s1_word};
      end
    end
  end

  assign line_0_out = win[0];
  assign line_1_out = win[1];
  assign line_2_out = win[2];
  assign line_3_out = win[3];
  assign line_4_out = win[4];
  assign line_5_out = win[5];
  assign line_6_out = win[6];

endmodule

// File: tb/tb_window_feeder.sv
// tb/tb_window_feeder.sv - self-checking bench for window_feeder
module tb_window_feeder;

  typedef logic [6:0][223:0] win_t;

  localparam logic [223:0] FIRST_L0 = {32'h0000_0000, 32'h3F80_0000, 32'h4000_0000,
                                       32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
                                       32'h40C0_0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [7:0]   b_pix, s_pix;
  logic         b_valid, b_sof, s_valid, s_sof;
  logic         b_de, s_de;
  logic [223:0] b_l0, b_l1, b_l2, b_l3, b_l4, b_l5, b_l6;
  logic [223:0] s_l0, s_l1, s_l2, s_l3, s_l4, s_l5, s_l6;

  int     checks = 0;
  int     errors = 0;
  bit     de_q[$];
  win_t   win_q[$];
  int     img[28][28];
  bit     chk_en = 1'b0;
  int     win_cnt = 0;
  bit     first_seen = 1'b0;
  logic [223:0] first_l0 = '0;
  win_t   dut_w, prev_w;

  window_feeder #(.IMG_W(28), .IMG_H(28)) u_big (
    .clk(clk), .reset(reset), .pix_in(b_pix), .pix_valid(b_valid), .sof_in(b_sof),
    .de_out(b_de), .line_0_out(b_l0), .line_1_out(b_l1), .line_2_out(b_l2),
    .line_3_out(b_l3), .line_4_out(b_l4), .line_5_out(b_l5), .line_6_out(b_l6)
  );

  window_feeder #(.IMG_W(7), .IMG_H(7)) u_small (
    .clk(clk), .reset(reset), .pix_in(s_pix), .pix_valid(s_valid), .sof_in(s_sof),
    .de_out(s_de), .line_0_out(s_l0), .line_1_out(s_l1), .line_2_out(s_l2),
    .line_3_out(s_l3), .line_4_out(s_l4), .line_5_out(s_l5), .line_6_out(s_l6)
  );

  assign dut_w = {b_l6, b_l5, b_l4, b_l3, b_l2, b_l1, b_l0};

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f2b(input int p);
    int e;
    int pw;
    if (p == 0) return 32'h0;
    e = 0;
    pw = 1;
    while (pw * 2 <= p) begin
      pw = pw * 2;
      e++;
    end
    return {1'b0, 8'(127 + e), 23'((p - pw) << (23 - e))};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      b_valid = 1'b0;
      b_sof   = 1'b0;
    end
  endtask

  task automatic px(input logic [7:0] v, input bit sof, input int r, input int c);
    win_t w;
    @(posedge clk); #1;
    b_valid = 1'b1;
    b_sof   = sof;
    b_pix   = v;
    img[r][c] = int'(v);
    if (r >= 6 && c >= 6) begin
      for (int k = 0; k < 7; k++)
        for (int j = 0; j < 7; j++)
          w[k][223 - 32*j -: 32] = f2b(img[r-6+k][c-6+j]);
      de_q.push_back(1'b1);
      win_q.push_back(w);
    end else begin
      de_q.push_back(1'b0);
    end
  endtask

  task automatic frame(input int mode, input bit sof_first, input bit stall, input int npix);
    int r, c, v;
    for (int i = 0; i < npix; i++) begin
      r = (i / 28) % 28;
      c = i % 28;
      if (stall) idle($urandom_range(0, 5));
      v = (mode == 0) ? ((r + c) & 255) : ((r * 7 + c * 13 + 5) & 255);
      px(8'(v), sof_first && (i == 0), r, c);
    end
  endtask

  task automatic end_phase(input string name, input int exp_cnt);
    idle(5);
    chk(name, win_cnt, exp_cnt);
    chk("queue_drained", de_q.size(), 0);
  endtask

  task automatic conv_test(input logic [7:0] v, input logic [31:0] expw);
    for (int i = 0; i < 49; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_sof   = (i == 0);
      s_pix   = (i == 48) ? v : 8'd0;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    @(negedge clk);
    chk("conv_de_early", s_de, 0);
    @(posedge clk);
    @(negedge clk);
    chk("conv_de", s_de, 1);
    chk("conv_word", s_l6[31:0], expw);
    chk("conv_rest", s_l0 | s_l1 | s_l2 | s_l3 | s_l4 | s_l5 | {s_l6[223:32], 32'h0}, 0);
  endtask

  // Per-cycle comparison of the 28x28 instance against the model queues
  initial begin : compare
    bit   pv1, pv2, e;
    win_t w;
    pv1 = 1'b0;
    pv2 = 1'b0;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        pv1 = 1'b0;
        pv2 = 1'b0;
        prev_w = dut_w;
      end else begin
        if (pv2) begin
          e = 1'b0;
          if (de_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL de_queue: got de=%0b with no pixel expected", b_de);
          end else begin
            e = de_q.pop_front();
          end
          chk("de_timing", b_de, e);
          if (e) begin
            if (win_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL win_queue: got de=%0b with no window expected", b_de);
            end else begin
              w = win_q.pop_front();
              for (int k = 0; k < 7; k++) chk($sformatf("window_line%0d", k), dut_w[k], w[k]);
            end
          end
          if (b_de) begin
            win_cnt++;
            if (!first_seen) begin
              first_seen = 1'b1;
              first_l0   = b_l0;
            end
          end
        end else begin
          chk("de_gap", b_de, 0);
          for (int k = 0; k < 7; k++) chk($sformatf("hold_line%0d", k), dut_w[k], prev_w[k]);
        end
        prev_w = dut_w;
        pv2 = pv1;
        pv1 = b_valid;
      end
    end
  end

  initial begin
    reset   = 1'b0;
    b_pix   = 8'd0;
    b_valid = 1'b0;
    b_sof   = 1'b0;
    s_pix   = 8'd0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        img[r][c] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_de_big", b_de, 0);
    chk("reset_de_small", s_de, 0);
    chk("reset_lines_big", b_l0 | b_l1 | b_l2 | b_l3 | b_l4 | b_l5 | b_l6, 0);
    chk("reset_lines_small", s_l0 | s_l1 | s_l2 | s_l3 | s_l4 | s_l5 | s_l6, 0);
    reset = 1'b1;
    idle(3);
    chk_en = 1'b1;

    conv_test(8'd1,   32'h3F80_0000);
    conv_test(8'd128, 32'h4300_0000);
    conv_test(8'd255, 32'h437F_0000);

    win_cnt = 0; first_seen = 1'b0;
    frame(0, 1'b1, 1'b0, 784);
    end_phase("full_frame_count", 484);
    chk("full_first_line0", first_l0, FIRST_L0);

    win_cnt = 0; first_seen = 1'b0;
    frame(0, 1'b1, 1'b1, 784);
    end_phase("stall_frame_count", 484);
    chk("stall_first_line0", first_l0, FIRST_L0);

    frame(0, 1'b1, 1'b0, 293);
    @(posedge clk); #1;
    chk_en  = 1'b0;
    b_valid = 1'b0;
    b_sof   = 1'b0;
    reset   = 1'b0;
    de_q.delete();
    win_q.delete();
    #1;
    chk("midreset_de", b_de, 0);
    chk("midreset_lines", b_l0 | b_l1 | b_l2 | b_l3 | b_l4 | b_l5 | b_l6, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(3);
    chk_en = 1'b1;
    win_cnt = 0; first_seen = 1'b0;
    frame(1, 1'b0, 1'b0, 784);
    end_phase("after_reset_count", 484);

    frame(0, 1'b1, 1'b0, 300);
    idle(4);
    win_cnt = 0; first_seen = 1'b0;
    frame(1, 1'b1, 1'b0, 784);
    end_phase("sof_resync_count", 484);

    win_cnt = 0; first_seen = 1'b0;
    frame(0, 1'b1, 1'b0, 784);
    frame(1, 1'b0, 1'b0, 784);
    end_phase("back_to_back_count", 968);
    chk("b2b_first_line0", first_l0, FIRST_L0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
